pipeline_mem_stage: RTL and testbench

//  Consumer end of the EX/MEM pipeline register in the scalar pipeline. Takes ALU result,

---
 rtl/pipeline_pkg.sv | 11 +
 rtl/mem_wait_counter.sv | 28 ++
 rtl/pipeline_mem_stage.sv | 139 +++++++++++++
 tb/tb_pipeline_mem_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and widths for the scalar pipeline memory stage.
package pipeline_pkg;
   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} mem_state_t;

   localparam int REG_IDX_W = 4;
   localparam int DATA_W    = 32;

   function automatic logic is_word_aligned(input logic [1:0] low_bits);
      return (low_bits == 2'b00);
   endfunction
endpackage

// File: rtl/mem_wait_counter.sv
// Counts ACCESS cycles; terminal count flags the last cycle before a memory timeout.
module mem_wait_counter #(
   parameter int MAX_WAIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int CW = $clog2(MAX_WAIT);
   localparam logic [CW-1:0] TC_VAL = CW'(MAX_WAIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == TC_VAL);
endmodule

// File: rtl/pipeline_mem_stage.sv
// MEM stage: data-memory access over req/ready, upstream stall, and the MEM/WB register.
module pipeline_mem_stage
   import pipeline_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int MAX_WAIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rmem_i,
   input  logic                 wmem_i,
   input  logic                 wreg_i,
   input  logic [DATA_W-1:0]    alu_res_i,
   input  logic [DATA_W-1:0]    r3_i,
   input  logic [REG_IDX_W-1:0] dest_reg_i,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   input  logic                 mem_ready,
   output logic                 stall,
   output logic                 wb_wreg,
   output logic [REG_IDX_W-1:0] wb_dest,
   output logic [DATA_W-1:0]    wb_data,
   output logic                 mem_err
);
   mem_state_t           state_q, state_d;
   logic                 req_q, req_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic                 wb_wreg_q, wb_wreg_d;
   logic [REG_IDX_W-1:0] wb_dest_q, wb_dest_d;
   logic [DATA_W-1:0]    wb_data_q, wb_data_d;
   logic                 err_q, err_d;
   logic                 cnt_clr, cnt_en, cnt_tc;
   logic                 mem_op;

   mem_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .tc_o  (cnt_tc)
   );

   assign mem_op = rmem_i | wmem_i;

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wb_wreg_d = wb_wreg_q;
      wb_dest_d = wb_dest_q;
      wb_data_d = wb_data_q;
      err_d     = err_q;
      stall     = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!mem_op) begin
               wb_wreg_d = wreg_i;
               wb_dest_d = dest_reg_i;
               wb_data_d = alu_res_i;
            end else if (is_word_aligned(alu_res_i[1:0])) begin
               // Request cycle: WB gets a bubble, the access completes from ACCESS.
               stall     = 1'b1;
               state_d   = ACCESS;
               req_d     = 1'b1;
               we_d      = wmem_i;
               addr_d    = alu_res_i[ADDR_W-1:0];
               wdata_d   = r3_i;
               wb_wreg_d = 1'b0;
               cnt_clr   = 1'b1;
            end else begin
               wb_wreg_d = 1'b0;
               err_d     = 1'b1;
            end
         end
         ACCESS: begin
            cnt_en = 1'b1;
            // Ready takes priority over a coincident timeout.
            if (mem_ready) begin
               state_d   = IDLE;
               req_d     = 1'b0;
               wb_dest_d = dest_reg_i;
               wb_wreg_d = we_q ? 1'b0 : wreg_i;
               if (!we_q) wb_data_d = mem_rdata;
            end else if (cnt_tc) begin
               state_d   = IDLE;
               req_d     = 1'b0;
               err_d     = 1'b1;
               wb_wreg_d = 1'b0;
               wb_data_d = '0;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wb_wreg_q <= 1'b0;
         wb_dest_q <= '0;
         wb_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wb_wreg_q <= wb_wreg_d;
         wb_dest_q <= wb_dest_d;
         wb_data_q <= wb_data_d;
         err_q     <= err_d;
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign wb_wreg   = wb_wreg_q;
   assign wb_dest   = wb_dest_q;
   assign wb_data   = wb_data_q;
   assign mem_err   = err_q;
endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed bench for pipeline_mem_stage with hand-computed expectations.
module tb_pipeline_mem_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        rmem_i, wmem_i, wreg_i;
   logic [31:0] alu_res_i, r3_i;
   logic [3:0]  dest_reg_i;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ready, stall, wb_wreg, mem_err;
   logic [3:0]  wb_dest;
   logic [31:0] wb_data;

   int passed = 0;
   int total  = 0;
   int stall_cnt;

   pipeline_mem_stage #(.ADDR_W(16), .MAX_WAIT(16)) dut (
      .clk(clk), .rst(rst), .rmem_i(rmem_i), .wmem_i(wmem_i), .wreg_i(wreg_i),
      .alu_res_i(alu_res_i), .r3_i(r3_i), .dest_reg_i(dest_reg_i),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
      .wb_wreg(wb_wreg), .wb_dest(wb_dest), .wb_data(wb_data), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rmem_i = 0; wmem_i = 0; wreg_i = 0;
      alu_res_i = 0; r3_i = 0; dest_reg_i = 0;
      mem_ready = 0; mem_rdata = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, 32'(mem_req), 0);
      chk({tag, "_we"}, 32'(mem_we), 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_wbwreg"}, 32'(wb_wreg), 0);
      chk({tag, "_wbdest"}, 32'(wb_dest), 0);
      chk({tag, "_wbdata"}, wb_data, 0);
      chk({tag, "_err"}, 32'(mem_err), 0);
   endtask

   task automatic alu_op(input string tag, input logic [3:0] d, input logic [31:0] v);
      rmem_i = 0; wmem_i = 0; wreg_i = 1; dest_reg_i = d; alu_res_i = v;
      #1 chk({tag, "_stall"}, 32'(stall), 0);
      step();
      chk({tag, "_wreg"}, 32'(wb_wreg), 1);
      chk({tag, "_dest"}, 32'(wb_dest), 32'(d));
      chk({tag, "_data"}, wb_data, v);
      chk({tag, "_req"}, 32'(mem_req), 0);
      idle_inputs();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 0;
      idle_inputs();
      step(); step();
      chk_all_zero("reset");
      chk("reset_stall", 32'(stall), 0);
      rst = 1;
      step();

      // Plain ALU op
      alu_op("alu", 4'd5, 32'h1234);

      // Load at 0x40, ready in the 4th ACCESS cycle
      rmem_i = 1; wreg_i = 1; dest_reg_i = 4'd7; alu_res_i = 32'h40;
      stall_cnt = 0;
      #1 if (stall) stall_cnt++;
      step();
      chk("ld_req", 32'(mem_req), 1);
      chk("ld_we", 32'(mem_we), 0);
      chk("ld_addr", 32'(mem_addr), 32'h40);
      chk("ld_bubble", 32'(wb_wreg), 0);
      for (int i = 0; i < 3; i++) begin
         #1 if (stall) stall_cnt++;
         step();
      end
      mem_ready = 1; mem_rdata = 32'hCAFEF00D;
      #1 chk("ld_ready_stall", 32'(stall), 0);
      step();
      idle_inputs();
      chk("ld_stall_cycles", 32'(stall_cnt), 4);
      chk("ld_wbdata", wb_data, 32'hCAFEF00D);
      chk("ld_wbwreg", 32'(wb_wreg), 1);
      chk("ld_wbdest", 32'(wb_dest), 7);
      chk("ld_req_drop", 32'(mem_req), 0);

      // Store at 0x80, ready after one cycle; wreg_i=1 must not write back
      wmem_i = 1; wreg_i = 1; dest_reg_i = 4'd3; alu_res_i = 32'h80; r3_i = 32'hA5A5A5A5;
      #1 chk("st_req_stall", 32'(stall), 1);
      step();
      chk("st_req", 32'(mem_req), 1);
      chk("st_we", 32'(mem_we), 1);
      chk("st_addr", 32'(mem_addr), 32'h80);
      chk("st_wdata", mem_wdata, 32'hA5A5A5A5);
      #1 chk("st_wait_stall", 32'(stall), 1);
      step();
      chk("st_held_wdata", mem_wdata, 32'hA5A5A5A5);
      mem_ready = 1;
      #1 chk("st_ready_stall", 32'(stall), 0);
      step();
      idle_inputs();
      chk("st_req_drop", 32'(mem_req), 0);
      chk("st_wbwreg", 32'(wb_wreg), 0);
      chk("st_wbdest", 32'(wb_dest), 3);
      chk("st_err", 32'(mem_err), 0);

      // Misaligned load
      rmem_i = 1; wreg_i = 1; dest_reg_i = 4'd4; alu_res_i = 32'h42;
      #1 chk("mis_stall", 32'(stall), 0);
      step();
      idle_inputs();
      chk("mis_req", 32'(mem_req), 0);
      chk("mis_err", 32'(mem_err), 1);
      chk("mis_wbwreg", 32'(wb_wreg), 0);
      step();
      chk("mis_err_sticky", 32'(mem_err), 1);

      // Reset clears the sticky error
      rst = 0;
      #1 chk("rst_err_clr", 32'(mem_err), 0);
      step();
      rst = 1;
      step();

      // Load that never gets ready: times out after 16 ACCESS cycles
      rmem_i = 1; wreg_i = 1; dest_reg_i = 4'd9; alu_res_i = 32'h100;
      step();
      chk("to_req", 32'(mem_req), 1);
      stall_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         #1 if (stall) stall_cnt++;
         step();
      end
      chk("to_wait_stalls", 32'(stall_cnt), 15);
      chk("to_req_held", 32'(mem_req), 1);
      chk("to_err_pending", 32'(mem_err), 0);
      #1 chk("to_last_stall", 32'(stall), 0);
      step();
      idle_inputs();
      chk("to_err", 32'(mem_err), 1);
      chk("to_req_drop", 32'(mem_req), 0);
      chk("to_wbwreg", 32'(wb_wreg), 0);
      chk("to_wbdata", wb_data, 0);

      // Reset asserted in the 2nd ACCESS cycle
      rst = 0;
      step();
      rst = 1;
      step();
      rmem_i = 1; wreg_i = 1; dest_reg_i = 4'd2; alu_res_i = 32'h200;
      step();
      step();
      chk("mid_req_before", 32'(mem_req), 1);
      rst = 0;
      #1 chk_all_zero("midrst");
      idle_inputs();
      #1 chk("midrst_stall", 32'(stall), 0);
      step();
      rst = 1;
      step();
      chk("post_rst_req", 32'(mem_req), 0);
      alu_op("post_alu", 4'd11, 32'hDEAD_BEEF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
